// File: rtl/line_buffer_reader.sv
// Line buffer read-side controller: fetches one scanline through a
// 2-entry prefetch FIFO and streams it with horizontal pixel repeat.
module line_buffer_reader #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 24,
    parameter int SCALE_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] line_len,
    input  logic [SCALE_W-1:0] h_scale,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ce,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0]  reads_left;
    logic [ADDR_W-1:0]  pix_left;
    logic [SCALE_W-1:0] scale_m1;
    logic [SCALE_W-1:0] rep;
    logic               in_flight;
    logic [DATA_W-1:0]  fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_cnt;

    logic       accept;
    logic       fire;
    logic       pop;
    logic       final_hs;
    logic [2:0] level;

    assign busy      = (state != IDLE);
    assign pix_valid = (fifo_cnt != 2'd0);
    assign pix_data  = fifo_mem[rd_ptr];
    assign pix_last  = pix_valid && (pix_left == ADDR_W'(1)) && (rep == scale_m1);

    assign accept   = start && !abort && !done && (state == IDLE);
    assign fire     = pix_valid && pix_ready;
    assign pop      = fire && (rep == scale_m1);
    assign final_hs = fire && pix_last;

    // Occupancy counts this cycle's pop so the FIFO can refill back-to-back.
    assign level = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, in_flight};
    assign rd_ce = (state == FETCH) && (reads_left != '0) &&
                   (level < 3'd2) && !abort;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && (line_len != '0)) state_nx = FETCH;
            end
            FETCH: begin
                if (rd_ce && (reads_left == ADDR_W'(1))) state_nx = DRAIN;
            end
            DRAIN: begin
                if (final_hs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            done        <= 1'b0;
            rd_addr     <= '0;
            reads_left  <= '0;
            pix_left    <= '0;
            scale_m1    <= '0;
            rep         <= '0;
            in_flight   <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            state     <= state_nx;
            done      <= !abort && ((accept && (line_len == '0)) ||
                                    ((state == DRAIN) && final_hs));
            in_flight <= rd_ce;
            if (abort) begin
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                fifo_cnt <= 2'd0;
                rep      <= '0;
            end else begin
                if (accept) begin
                    rd_addr    <= base_addr;
                    reads_left <= line_len;
                    pix_left   <= line_len;
                    scale_m1   <= (h_scale == '0) ? '0 : h_scale - 1'b1;
                    rep        <= '0;
                end
                if (rd_ce) begin
                    rd_addr    <= rd_addr + 1'b1;
                    reads_left <= reads_left - 1'b1;
                end
                if (in_flight) begin
                    fifo_mem[wr_ptr] <= rd_data;
                    wr_ptr           <= ~wr_ptr;
                end
                if (fire) rep <= pop ? '0 : rep + 1'b1;
                if (pop) begin
                    rd_ptr   <= ~rd_ptr;
                    pix_left <= pix_left - 1'b1;
                end
                fifo_cnt <= fifo_cnt + {1'b0, in_flight} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_reader.sv
// Randomised self-checking bench for line_buffer_reader with a
// queue-based scanline model and a few hand-computed pin checks.
`timescale 1ns/1ps
module tb_line_buffer_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [11:0] line_len;
    logic [2:0]  h_scale;
    logic        busy;
    logic        done;
    logic [11:0] rd_addr;
    logic        rd_ce;
    logic [23:0] rd_data;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;

    line_buffer_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .line_len(line_len), .h_scale(h_scale),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_ce(rd_ce),
        .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [4096];
    always @(posedge clk) if (rd_ce) rd_data <= mem[rd_addr];

    int total = 0;
    int bad = 0;
    int ready_pct = 100;
    int cur_scale = 1;
    int n_rd, n_pop, n_hs, n_done_line;
    logic [11:0] exp_addr[$];
    logic [23:0] exp_pix[$];
    logic [11:0] seen_addr[$];
    logic [23:0] seen_pix[$];
    logic        prev_stall, prev_last, prev_abort;
    logic [23:0] prev_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event want none", nm);
    endtask

    always @(posedge clk) begin
        #1;
        pix_ready = ($urandom_range(99) < ready_pct);
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_data", pix_data, prev_d);
                chk("stall_last", pix_last, prev_last);
            end
            if (pix_valid && exp_pix.size() == 0) begin
                flag("valid_no_pixel");
            end else if (pix_valid && pix_ready) begin
                seen_pix.push_back(pix_data);
                chk("pix_data", pix_data, exp_pix[0]);
                chk("pix_last", pix_last, exp_pix.size() == 1);
                void'(exp_pix.pop_front());
                n_hs++;
                if (n_hs % cur_scale == 0) n_pop++;
            end
            if (rd_ce) begin
                seen_addr.push_back(rd_addr);
                n_rd++;
                if (exp_addr.size() == 0) flag("rd_ce_extra");
                else chk("rd_addr", rd_addr, exp_addr.pop_front());
                chk("fifo_no_overflow", (n_rd - n_pop) <= 2, 1);
            end
            if (done) begin
                n_done_line++;
                chk("done_drained", exp_pix.size(), 0);
            end
            prev_stall = pix_valid && !pix_ready;
            prev_d     = pix_data;
            prev_last  = pix_last;
            prev_abort = abort;
        end
    end

    task automatic clear_model();
        exp_addr.delete();
        exp_pix.delete();
        seen_addr.delete();
        seen_pix.delete();
        n_rd = 0; n_pop = 0; n_hs = 0; n_done_line = 0;
    endtask

    task automatic launch(input logic [11:0] b, input logic [11:0] l, input logic [2:0] s);
        int se;
        logic [11:0] a;
        se = (s == 0) ? 1 : int'(s);
        @(posedge clk); #1;
        clear_model();
        cur_scale = se;
        base_addr = b; line_len = l; h_scale = s; start = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 12'(i);
            exp_addr.push_back(a);
            for (int r = 0; r < se; r++) exp_pix.push_back(mem[a]);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_line(input int l, input int se, input int budget);
        int k = 0;
        while (n_done_line == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_done_line == 0) flag("done_timeout");
        repeat (3) @(negedge clk);
        chk("done_once", n_done_line, 1);
        chk("hs_total", n_hs, l * se);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 24'(i);
        pix_ready = 1'b1;
        reset_n = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'($urandom); abort = 1'($urandom);
            base_addr = 12'($urandom); line_len = 12'($urandom); h_scale = 3'($urandom);
            @(negedge clk);
            chk("rst_ctrl", {busy, done, rd_ce, pix_valid, pix_last}, 0);
            chk("rst_data", {rd_addr, pix_data}, 0);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst", {busy, done, rd_ce, pix_valid, rd_addr}, 0);
        end

        ready_pct = 100;
        launch(12'h010, 12'd4, 3'd1);
        @(negedge clk);
        chk("c1_rd_ce", rd_ce, 1);
        chk("c1_rd_addr", rd_addr, 12'h010);
        @(negedge clk);
        chk("c2_valid", pix_valid, 0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            chk("basic_valid", pix_valid, 1);
            chk("basic_data", pix_data, 24'h10 + 24'(c - 3));
            chk("basic_last", pix_last, c == 6);
        end
        @(negedge clk);
        chk("c7_done", done, 1);
        chk("c7_busy", busy, 0);
        @(negedge clk);
        chk("c8_done", done, 0);

        ready_pct = 50;
        launch(12'h020, 12'd3, 3'd3);
        finish_line(3, 3, 400);
        chk("scale_len", seen_pix.size(), 9);
        for (int k = 0; k < 9 && k < seen_pix.size(); k++)
            chk("scale_seq", seen_pix[k], 24'h20 + 24'(k / 3));

        ready_pct = 100;
        launch(12'hFFE, 12'd4, 3'd1);
        finish_line(4, 1, 100);
        chk("wrap_n", seen_addr.size(), 4);
        if (seen_addr.size() == 4) begin
            chk("wrap_a0", seen_addr[0], 12'hFFE);
            chk("wrap_a1", seen_addr[1], 12'hFFF);
            chk("wrap_a2", seen_addr[2], 12'h000);
            chk("wrap_a3", seen_addr[3], 12'h001);
        end

        launch(12'h123, 12'd0, 3'd2);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("zero_reads", n_rd, 0);
        chk("zero_done_once", n_done_line, 1);

        launch(12'h200, 12'd2, 3'd0);
        finish_line(2, 1, 100);

        ready_pct = 100;
        launch(12'h300, 12'd8, 3'd1);
        begin
            int k = 0;
            while (n_hs < 2 && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (n_hs < 2) flag("abort_wait_timeout");
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        clear_model();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix_valid, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", n_done_line, 0);
        launch(12'h500, 12'd5, 3'd2);
        finish_line(5, 2, 200);

        ready_pct = 50;
        launch(12'h600, 12'd6, 3'd2);
        repeat (12) begin
            @(posedge clk); #1;
            if (busy) begin
                start = 1'b1; base_addr = 12'h0AA; line_len = 12'd9;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        finish_line(6, 2, 400);

        for (int i = 0; i < 4096; i++) mem[i] = {12'($urandom), 12'(i)};
        for (int n = 0; n < 25; n++) begin
            int l, s;
            l = $urandom_range(24);
            s = $urandom_range(7);
            ready_pct = 25 * $urandom_range(1, 4);
            launch(12'($urandom), 12'(l), 3'(s));
            finish_line(l, (s == 0) ? 1 : s, 1500);
            repeat ($urandom_range(3)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
